// File: rtl/ula.sv
// Registered 8-bit ALU: 16 ops on A/B selected by ULA_Sel, with a carry/flag bit.
// Latency 1 cycle (result registered on rising clock); no backpressure, accepts an op every cycle.
// Define ULA_SATURATE_EN to clamp ADD/SUB/MUL overflow instead of wrapping.
module ula #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ULA_Sel,
    output logic [WIDTH-1:0] ULA_Out,
    output logic             CarryOut
);

    logic [WIDTH-1:0]   res_d, res_q;
    logic               carry_d, carry_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    // Guarded divide keeps the divider's output defined when B is zero.
    assign quot = (B == '0) ? '1 : A / B;

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (ULA_Sel)
            4'd0: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
`ifdef ULA_SATURATE_EN
                if (sum[WIDTH]) res_d = '1;
`endif
            end
            4'd1: begin
                res_d   = diff[WIDTH-1:0];
                carry_d = (A < B);
`ifdef ULA_SATURATE_EN
                if (A < B) res_d = '0;
`endif
            end
            4'd2: begin
                res_d   = prod[WIDTH-1:0];
                carry_d = (prod[2*WIDTH-1:WIDTH] != '0);
`ifdef ULA_SATURATE_EN
                if (prod[2*WIDTH-1:WIDTH] != '0) res_d = '1;
`endif
            end
            4'd3: begin
                res_d   = quot;
                carry_d = (B == '0);
            end
            4'd4: begin
                res_d   = {A[WIDTH-2:0], 1'b0};
                carry_d = A[WIDTH-1];
            end
            4'd5: begin
                res_d   = {1'b0, A[WIDTH-1:1]};
                carry_d = A[0];
            end
            4'd6:  res_d = {A[WIDTH-2:0], A[WIDTH-1]};
            4'd7:  res_d = {A[0], A[WIDTH-1:1]};
            4'd8:  res_d = A & B;
            4'd9:  res_d = A | B;
            4'd10: res_d = A ^ B;
            4'd11: res_d = ~(A | B);
            4'd12: res_d = ~(A & B);
            4'd13: res_d = ~(A ^ B);
            4'd14: res_d = {{(WIDTH-1){1'b0}}, (A > B)};
            4'd15: res_d = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            res_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            carry_q <= carry_d;
        end
    end

    assign ULA_Out  = res_q;
    assign CarryOut = carry_q;

endmodule

// File: tb/tb_ula.sv
// Bench for ula: directed cases plus random ops against an integer-arithmetic reference model.
module tb_ula;

    logic       clock;
    logic       reset;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ULA_Sel;
    logic [7:0] ULA_Out;
    logic       CarryOut;

    int n_cmp;
    int n_bad;

    ula #(.WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .A        (A),
        .B        (B),
        .ULA_Sel  (ULA_Sel),
        .ULA_Out  (ULA_Out),
        .CarryOut (CarryOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got carry=%0b out=%02h, expected carry=%0b out=%02h",
                     tag, obs[8], obs[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Returns carry*256 + result, computed with plain integer arithmetic.
    function automatic int model(input int sel, input int a, input int b);
        int t, r, c;
        r = 0;
        c = 0;
        case (sel)
            0: begin
                t = a + b; r = t % 256; c = (t > 255);
`ifdef ULA_SATURATE_EN
                if (c != 0) r = 255;
`endif
            end
            1: begin
                r = (a - b + 256) % 256; c = (a < b);
`ifdef ULA_SATURATE_EN
                if (c != 0) r = 0;
`endif
            end
            2: begin
                t = a * b; r = t % 256; c = (t > 255);
`ifdef ULA_SATURATE_EN
                if (c != 0) r = 255;
`endif
            end
            3: begin
                if (b == 0) begin r = 255; c = 1; end
                else r = a / b;
            end
            4: begin r = (a * 2) % 256; c = (a >= 128); end
            5: begin r = a / 2; c = a % 2; end
            6: r = (a * 2) % 256 + a / 128;
            7: r = a / 2 + (a % 2) * 128;
            8: r = a & b;
            9: r = a | b;
            10: r = a ^ b;
            11: r = (~(a | b)) & 255;
            12: r = (~(a & b)) & 255;
            13: r = (~(a ^ b)) & 255;
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return c * 256 + r;
    endfunction

    function automatic logic [8:0] mexp(input int sel, input int a, input int b);
        int v;
        v = model(sel, a, b);
        return v[8:0];
    endfunction

    // Drive on the falling edge, let one rising edge capture, sample just after it.
    task automatic run_op(input string tag, input int sel, input int a, input int b,
                          input logic [8:0] exp);
        @(negedge clock);
        ULA_Sel = sel[3:0];
        A       = a[7:0];
        B       = b[7:0];
        @(posedge clock);
        #1;
        chk(tag, {CarryOut, ULA_Out}, exp);
    endtask

    logic [8:0] sweep_exp [4:15];
    logic [8:0] sat_add, sat_sub, sat_mul;

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef ULA_SATURATE_EN
        sat_add = 9'h1FF; sat_sub = 9'h100; sat_mul = 9'h1FF;
`else
        sat_add = 9'h100; sat_sub = 9'h1FF; sat_mul = 9'h100;
`endif
        sweep_exp[4]  = 9'h102; sweep_exp[5]  = 9'h140;
        sweep_exp[6]  = 9'h003; sweep_exp[7]  = 9'h0C0;
        sweep_exp[8]  = 9'h001; sweep_exp[9]  = 9'h08F;
        sweep_exp[10] = 9'h08E; sweep_exp[11] = 9'h070;
        sweep_exp[12] = 9'h0FE; sweep_exp[13] = 9'h071;
        sweep_exp[14] = 9'h001; sweep_exp[15] = 9'h000;

        reset   = 1'b0;
        A       = 8'h55;
        B       = 8'hAA;
        ULA_Sel = 4'd0;
        #1;
        chk("reset_t0", {CarryOut, ULA_Out}, 9'h000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            chk("reset_held", {CarryOut, ULA_Out}, 9'h000);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("first_after_release", {CarryOut, ULA_Out}, 9'h0FF);

        run_op("add_wrap", 0, 8'hFF, 8'h01, sat_add);
        run_op("div", 3, 8'h64, 8'h0A, 9'h00A);
        run_op("div_by_zero", 3, 8'h10, 8'h00, 9'h1FF);
        run_op("sub_wrap", 1, 8'h00, 8'h01, sat_sub);
        run_op("mul_ovf", 2, 8'h10, 8'h10, sat_mul);
        for (int s = 4; s < 16; s++)
            run_op($sformatf("sweep_sel%0d", s), s, 8'h81, 8'h0F, sweep_exp[s]);

        for (int i = 0; i < 400; i++) begin
            int sel, a, b;
            sel = $urandom_range(0, 15);
            a   = $urandom_range(0, 255);
            b   = (i % 16 == 0) ? 0 : $urandom_range(0, 255);
            run_op($sformatf("rand%0d_sel%0d_a%02h_b%02h", i, sel, a, b), sel, a, b,
                   mexp(sel, a, b));
        end

        run_op("pre_reset_op", 9, 8'hF0, 8'h0F, 9'h0FF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_drop", {CarryOut, ULA_Out}, 9'h000);
        @(negedge clock);
        ULA_Sel = 4'd4;
        A       = 8'hC3;
        @(posedge clock);
        #1;
        chk("reset_held_mid", {CarryOut, ULA_Out}, 9'h000);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("post_reset_op", {CarryOut, ULA_Out}, mexp(4, 8'hC3, 0));
        run_op("post_reset_next", 15, 8'h3C, 8'h3C, 9'h001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
